// File: rtl/fetch_pkg.sv
// Shared fetch-queue types and sizing.
// Holds queue depth default, fetch/decode widths and the entry layout.
package fetch_pkg;

    localparam int IFQ_DEPTH   = 16;
    localparam int FETCH_WIDTH = 4;
    localparam int DEC_WIDTH   = 2;

    typedef struct packed {
        logic [31:2] pc;
        logic [31:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/fetch_lane_compact.sv
// Packs the valid lanes of a fetch group into consecutive slots, lane order.
// Ports: lane_vld/pc_stage2/lane_inst in; ent (compacted entries), n (count) out.
module fetch_lane_compact
    import fetch_pkg::*;
(
    input  logic [FETCH_WIDTH-1:0]       lane_vld,
    input  logic [31:0]                  pc_stage2,
    input  logic [FETCH_WIDTH-1:0][31:0] lane_inst,
    output ifq_entry_t [FETCH_WIDTH-1:0] ent,
    output logic [2:0]                   n
);

    always_comb begin
        ent = '0;
        n   = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (lane_vld[k]) begin
                // Lane PC is the group base plus 4*k; bits [3:2] are the lane.
                ent[n[1:0]].pc   = {pc_stage2[31:4], 2'(k)};
                ent[n[1:0]].inst = lane_inst[k];
                n = n + 3'd1;
            end
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between I-cache stage 2 and decode.
// Ports: clk, rst_n, flush; fetch group in (PC_stage2, 4 lanes); fetch_hold out;
// dec_ready in; two oldest entries out (out0/out1 vld, inst, PC).
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] PC_stage2,
    input  logic        instruction0_vld,
    input  logic        instruction1_vld,
    input  logic        instruction2_vld,
    input  logic        instruction3_vld,
    input  logic [31:0] instruction0,
    input  logic [31:0] instruction1,
    input  logic [31:0] instruction2,
    input  logic [31:0] instruction3,
    output logic        fetch_hold,
    input  logic        dec_ready,
    output logic        out0_vld,
    output logic        out1_vld,
    output logic [31:0] out0_inst,
    output logic [31:0] out1_inst,
    output logic [31:0] out0_PC,
    output logic [31:0] out1_PC
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] count, free_cnt;

    ifq_entry_t mem_q [DEPTH];
    ifq_entry_t mem_d [DEPTH];

    ifq_entry_t [FETCH_WIDTH-1:0] ent;
    logic [2:0]                   n;
    logic [FETCH_WIDTH-1:0]       lane_vld;
    logic                         push_en;
    logic [1:0]                   m;
    logic [AW-1:0]                rd0, rd1;

    assign lane_vld = {instruction3_vld, instruction2_vld,
                       instruction1_vld, instruction0_vld};

    fetch_lane_compact u_compact (
        .lane_vld  (lane_vld),
        .pc_stage2 (PC_stage2),
        .lane_inst ({instruction3, instruction2, instruction1, instruction0}),
        .ent       (ent),
        .n         (n)
    );

    // Wrap bit makes full (count == DEPTH) distinct from empty.
    assign count      = wr_ptr_q - rd_ptr_q;
    assign free_cnt   = PW'(DEPTH) - count;
    assign fetch_hold = free_cnt < PW'(FETCH_WIDTH);
    assign out0_vld   = count != '0;
    assign out1_vld   = count >= PW'(DEC_WIDTH);
    assign push_en    = (|lane_vld) & ~fetch_hold & ~flush;

    always_comb begin
        m = '0;
        if (dec_ready && !flush)
            m = {1'b0, out0_vld} + {1'b0, out1_vld};
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_en) begin
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    if (3'(i) < n)
                        mem_d[wr_ptr_q[AW-1:0] + AW'(i)] = ent[i];
                end
                wr_ptr_d = wr_ptr_q + PW'(n);
            end
            rd_ptr_d = rd_ptr_q + PW'(m);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; slots are only read behind a valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd0 = rd_ptr_q[AW-1:0];
    assign rd1 = rd0 + AW'(1);

    assign out0_inst = mem_q[rd0].inst;
    assign out1_inst = mem_q[rd1].inst;
    assign out0_PC   = {mem_q[rd0].pc, 2'b00};
    assign out1_PC   = {mem_q[rd1].pc, 2'b00};

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch queue between the L1 I-cache output stage and decode. Each cycle it accepts up to four valid instructions from I-cache stage 2, compacts them in lane order and stores each with its PC. It presents the two oldest instructions to decode and drops stage 1/2 through a hold when it cannot absorb a full fetch group. A redirect flush empties it in one cycle.

## Interface
- DEPTH, 16, entry count; power of two, at least 8
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  redirect/exception flush; empties the queue
- PC_stage2  in  32  fetch-group PC; lane k PC = {PC_stage2[31:4], 4'b0} + 4k
- instruction0_vld..instruction3_vld  in  1 each  lane valid; non-contiguous patterns are legal
- instruction0..instruction3  in  32 each  lane instruction word
- fetch_hold  out  1  to I-cache hold_stage1_2; high when free entries < 4
- dec_ready  in  1  decode accepts this cycle's presented instructions
- out0_vld, out1_vld  out  1 each  slot valid; out1_vld implies out0_vld
- out0_inst, out1_inst  out  32 each  instruction word
- out0_PC, out1_PC  out  32 each  instruction PC; bits [1:0] always 0

## Operation
- Storage: DEPTH entries of {PC[31:2], inst[31:0]}. rd_ptr and wr_ptr are log2(DEPTH)+1 bits with a wrap bit. count = wr_ptr - rd_ptr, modulo 2^(log2(DEPTH)+1).
- Push condition: push_en = |lane_vld & !fetch_hold & !flush.
- Push n = popcount(lane_vld), 0 to 4. Valid lanes are written in ascending lane order to wr_ptr, wr_ptr+1, and so on, modulo DEPTH. wr_ptr advances by n.
- Input data is ignored while fetch_hold is high. I-cache holds stage 2 and re-presents the same group.
- fetch_hold = (DEPTH - count) < 4. It is computed from registered count only; a same-cycle pop does not release it.
- Output slots:
  - out0 = entry[rd_ptr]; out0_vld = count ≥ 1.
  - out1 = entry[rd_ptr+1]; out1_vld = count ≥ 2.
  - Data on an invalid slot is don't-care.
- Pop: when dec_ready and !flush, pop m = out0_vld + out1_vld, then rd_ptr += m. Decode takes both valid slots or neither.
- Simultaneous push and pop are allowed: count_next = count + n - m.
- Flush has the highest priority. rd_ptr and wr_ptr go to 0 and all out*_vld are low next cycle. Same-cycle input and dec_ready are ignored.
- Wrap-around: a push of 4 starting at entry DEPTH-2 writes DEPTH-2, DEPTH-1, 0, 1. The read of rd_ptr+1 wraps identically.
- Overflow cannot occur by construction. The bench asserts count ≤ DEPTH every cycle.

## Timing
- Reset values:
  - Pointers 0; fetch_hold 0.
  - out0_vld and out1_vld 0.
  - out*_inst and out*_PC read storage and are don't-care while invalid.
- Latency: a group pushed at edge N is visible on out0/out1 in cycle N+1.
- fetch_hold changes only one cycle after the edge that changed count.
- Reset asserted mid-operation empties the queue immediately, asynchronously. The first push is accepted on the first edge after deassertion.
- Outputs are combinational from registered pointers and storage, with no input-to-output combinational path. Exception: none; fetch_hold depends on state only.

## Structure
- Shared package fetch_pkg holds:
  - IFQ_DEPTH default (16).
  - FETCH_WIDTH = 4 and DEC_WIDTH = 2.
  - Typedef ifq_entry_t {pc[31:2], inst[31:0]}.
- Sub-module fetch_lane_compact, combinational: 4 valid bits plus data in, up to 4 compacted entries plus 3-bit count n out. It computes lane PCs from PC_stage2.
- The top level holds the pointers, the storage array, the write decode (offset i targets wr_ptr+i) and the output muxes.

## Test plan
- Reset, then push PC_stage2=0x1C000000 with all four lanes valid and dec_ready=0. Next cycle: out0_PC=0x1C000000, out1_PC=0x1C000004, count=4.
- Lanes vld=4'b1010 at PC_stage2=0x1C000010 into an empty queue. out0_PC=0x1C000014 (lane1), out1_PC=0x1C00001C (lane3), count=2.
- With dec_ready=0, push four full groups. fetch_hold=1 once count=16 (free < 4, DEPTH=16). The held group is not written. After dec_ready pops 2, fetch_hold stays high (free=2). After another pop of 2, fetch_hold drops next cycle.
- Steady state of push 4 and pop 2 per cycle. Pointers wrap past entry 15. PC order on out0/out1 is strictly +4 with no loss or duplication over 64 instructions.
- count=1 with dec_ready=1: out1_vld=0, one entry pops, and the queue is empty next cycle. A simultaneous push of 4 gives count=4.
- count=9 with flush=1 together with a 4-lane push and dec_ready=1: next cycle out0_vld=0, out1_vld=0, fetch_hold=0. A following push is visible one cycle later.
